// File: rtl/bdpsk_pkg.sv
// Shared definitions for the BDPSK transmit path.
// Holds the framing state encoding, the default sync byte and symbol
// length used by the encoder controller, and a counter-width helper.
package bdpsk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    PAYLOAD,
    TAIL
  } state_t;

  localparam logic [7:0] SYNC_WORD_DEF  = 8'hA7;
  localparam int         SYMBOL_LEN_DEF = 128;

  // Bits needed to count 0..n-1; never less than 1.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/bdpsk_symbol_timer.sv
// Symbol timer: counts clocks within a symbol and flags the last one.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   en         : count while high (frame in progress)
//   clr        : restart at 0 on the next clock (frame start)
//   strobe     : en && counter at SYMBOL_LEN-1
module bdpsk_symbol_timer
  import bdpsk_pkg::*;
#(
  parameter int SYMBOL_LEN = SYMBOL_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic strobe
);

  localparam int            CW   = clog2(SYMBOL_LEN);
  localparam logic [CW-1:0] LAST = CW'(SYMBOL_LEN - 1);

  logic [CW-1:0] sym_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)
      sym_cnt <= '0;
    else if (en)
      sym_cnt <= (sym_cnt == LAST) ? '0 : sym_cnt + CW'(1);
  end

  // Wrap coincides with the carrier table period, so the next symbol
  // (and any phase flip) starts on a table wrap.
  assign strobe = en && (sym_cnt == LAST);

endmodule

// File: rtl/bdpsk_frame_scheduler.sv
// BDPSK frame scheduler: builds preamble / sync / payload / tail,
// differentially encodes each raw bit and holds it on tx_bit for one
// symbol period.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start, frame_len  : frame request and payload byte count (IDLE only)
//   s_data/s_valid/s_ready : upstream payload byte handshake
//   tx_bit, tx_en     : encoded symbol and frame-active flag to encoder
//   sym_strobe        : last clock of each symbol
//   busy, done        : frame in progress / one-cycle end pulse
//   underrun          : sticky payload starvation flag
module bdpsk_frame_scheduler
  import bdpsk_pkg::*;
#(
  parameter int         SYMBOL_LEN    = SYMBOL_LEN_DEF,
  parameter int         PREAMBLE_BITS = 16,
  parameter logic [7:0] SYNC_WORD     = SYNC_WORD_DEF,
  parameter int         TAIL_BITS     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       tx_bit,
  output logic       tx_en,
  output logic       sym_strobe,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_BITS - 1);
  localparam logic [15:0] TAIL_LAST = 16'(TAIL_BITS - 1);

  state_t      state;
  logic [15:0] bit_cnt;    // symbol index within the current section
  logic [7:0]  shreg;      // remaining bits of the sync/payload byte, MSB next
  logic [7:0]  hold;       // one-entry payload holding buffer
  logic        hold_full;
  logic [8:0]  fetched;    // bytes accepted or written off as underrun
  logic [7:0]  len;
  logic [7:0]  byte_idx;   // payload bytes moved into shreg so far

  logic       start_acc;
  logic       xfer;
  logic       boundary;
  logic       ur_take;
  logic [7:0] next_byte;

  assign start_acc = (state == IDLE) && start;
  assign s_ready   = busy && !hold_full && (fetched < {1'b0, len});
  assign xfer      = s_valid && s_ready;

  // Byte boundary: last bit of SYNC or of a payload byte with payload left.
  always_comb begin
    boundary  = 1'b0;
    ur_take   = 1'b0;
    next_byte = hold_full ? hold : 8'h00;
    if (sym_strobe && (state == SYNC || state == PAYLOAD) &&
        bit_cnt == 16'd7 && byte_idx < len) begin
      boundary = 1'b1;
      ur_take  = !hold_full;
    end
  end

  bdpsk_symbol_timer #(.SYMBOL_LEN(SYMBOL_LEN)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (busy),
    .clr    (start_acc),
    .strobe (sym_strobe)
  );

  // tx_bit doubles as the differential encoder state d while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      fetched   <= '0;
      len       <= '0;
      byte_idx  <= '0;
      tx_bit    <= 1'b0;
      tx_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state     <= PREAMBLE;
          bit_cnt   <= '0;
          len       <= frame_len;
          byte_idx  <= '0;
          fetched   <= '0;
          hold_full <= 1'b0;
          underrun  <= 1'b0;
          busy      <= 1'b1;
          tx_en     <= 1'b1;
          tx_bit    <= 1'b1;   // first preamble '1' against d=0
        end
      end else begin
        if (sym_strobe) begin
          case (state)
            PREAMBLE: begin
              tx_bit <= tx_bit ^ (bit_cnt == PRE_LAST ? SYNC_WORD[7] : 1'b1);
              if (bit_cnt == PRE_LAST) begin
                state   <= SYNC;
                bit_cnt <= '0;
                shreg   <= {SYNC_WORD[6:0], 1'b0};
              end else begin
                bit_cnt <= bit_cnt + 16'd1;
              end
            end
            SYNC, PAYLOAD: begin
              if (bit_cnt != 16'd7) begin
                bit_cnt <= bit_cnt + 16'd1;
                tx_bit  <= tx_bit ^ shreg[7];
                shreg   <= {shreg[6:0], 1'b0};
              end else begin
                bit_cnt <= '0;
                if (boundary) begin
                  state     <= PAYLOAD;
                  byte_idx  <= byte_idx + 8'd1;
                  tx_bit    <= tx_bit ^ next_byte[7];
                  shreg     <= {next_byte[6:0], 1'b0};
                  hold_full <= 1'b0;
                  if (ur_take) underrun <= 1'b1;
                end else begin
                  state <= TAIL;   // raw 0: line holds
                end
              end
            end
            TAIL: begin
              if (bit_cnt == TAIL_LAST) begin
                state   <= IDLE;
                bit_cnt <= '0;
                busy    <= 1'b0;
                tx_en   <= 1'b0;
                tx_bit  <= 1'b0;
                done    <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 16'd1;
              end
            end
            default: ;
          endcase
        end
        // Only reachable with hold empty, so it overrides the boundary drain.
        if (xfer) begin
          hold      <= s_data;
          hold_full <= 1'b1;
        end
        fetched <= fetched + {8'd0, xfer} + {8'd0, ur_take};
      end
    end
  end

endmodule

// File: tb/tb_bdpsk_frame_scheduler.sv
module tb_bdpsk_frame_scheduler;

  localparam int SL = 4;
  localparam int PB = 4;
  localparam int TB = 2;
  localparam logic [7:0] SW = 8'hA7;

  logic       clk = 1'b0;
  logic       reset, start, s_valid;
  logic [7:0] frame_len, s_data;
  logic       s_ready, tx_bit, tx_en, sym_strobe, busy, done, underrun;

  bdpsk_frame_scheduler #(
    .SYMBOL_LEN(SL), .PREAMBLE_BITS(PB), .SYNC_WORD(SW), .TAIL_BITS(TB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .tx_bit(tx_bit), .tx_en(tx_en), .sym_strobe(sym_strobe),
    .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  logic [7:0] fbytes[8];
  int g_busy, g_hs, g_done;
  int g_sym[64];

  // Upstream ready windows: fetch j opens once byte j-1 leaves the buffer
  // (cycle 0 for the first byte). A supplied byte is taken on the spot;
  // a missing one keeps ready high until the boundary that needs it.
  function automatic bit exp_ready(input int c, input int len, input int avail);
    int o, e;
    for (int j = 0; j < len; j++) begin
      o = (j == 0) ? 0 : (PB + 8 + 8 * (j - 1)) * SL;
      e = (PB + 8 + 8 * j) * SL - 1;
      if (j < avail) begin
        if (c == o) return 1'b1;
      end else if (c >= o && c <= e) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Runs one frame from start, comparing every cycle against a model
  // derived from the raw bit list. inj: cycle of an extra start pulse;
  // rst_at: cycle at which reset is pulsed (frame then aborts).
  task automatic run_frame(input string tag, input int len, input int avail,
                           input int inj, input int rst_at);
    int raw[$];
    int enc[$];
    int n, d, bi, ur_from, b;
    logic [6:0] ev, av;
    bit eb;
    for (int i = 0; i < PB; i++) raw.push_back(1);
    for (int i = 7; i >= 0; i--) raw.push_back(int'(SW[i]));
    for (int j = 0; j < len; j++) begin
      b = (j < avail) ? int'(fbytes[j]) : 0;
      for (int i = 7; i >= 0; i--) raw.push_back((b >> i) & 1);
    end
    for (int i = 0; i < TB; i++) raw.push_back(0);
    d = 0;
    foreach (raw[i]) begin
      d = d ^ raw[i];
      enc.push_back(d);
    end
    n = raw.size();
    ur_from = (avail < len) ? (PB + 8 + 8 * avail) * SL : -1;

    g_busy = 0; g_hs = 0; g_done = 0;
    bi = 0;
    frame_len = 8'(len);
    start = 1'b1;
    s_valid = (avail > 0);
    s_data = fbytes[0];
    @(posedge clk); #1;
    start = 1'b0;
    frame_len = 8'($urandom);

    for (int c = 0; c <= n * SL + 2; c++) begin
      eb = (c < n * SL);
      ev = {eb, eb, eb ? enc[c / SL][0] : 1'b0, eb && (c % SL == SL - 1),
            c == n * SL, ur_from >= 0 && c >= ur_from, eb && exp_ready(c, len, avail)};
      if (rst_at >= 0 && c > rst_at) ev = '0;
      av = {busy, tx_en, tx_bit, sym_strobe, done, underrun, s_ready};
      chk($sformatf("%s c=%0d {busy,en,bit,stb,done,ur,rdy}", tag, c), int'(av), int'(ev));
      g_busy += int'(busy);
      g_done += int'(done);
      if (busy && (c % SL == 0) && c / SL < 64) g_sym[c / SL] = int'(tx_bit);
      if (rst_at >= 0 && c == rst_at + 4) break;

      reset = (rst_at >= 0 && c == rst_at);
      start = (c == inj);
      if (c == inj) frame_len = 8'(len + 3);
      s_valid = (bi < avail);
      s_data = fbytes[bi & 7];
      if (s_valid && s_ready && !reset) begin
        bi++;
        g_hs++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    s_valid = 1'b0;
    reset = 1'b0;
  endtask

  typedef struct {
    int         len;
    int         avail;
    logic [7:0] b0, b1, b2;
    int         exp_clk;
    int         exp_hs;
    int         exp_ur;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int sv, len, avail;
    tbl[0] = '{0, 0, 8'h00, 8'h00, 8'h00,  56, 0, 0};  // empty frame
    tbl[1] = '{1, 1, 8'h00, 8'h00, 8'h00,  88, 1, 0};  // one zero byte
    tbl[2] = '{3, 3, 8'hFF, 8'h01, 8'h80, 152, 3, 0};  // back-to-back
    tbl[3] = '{2, 1, 8'h5A, 8'h00, 8'h00, 120, 1, 1};  // second byte starved
    tbl[4] = '{1, 1, 8'h00, 8'h00, 8'h00,  88, 1, 0};  // start clears underrun

    reset = 1'b1; start = 1'b0; s_valid = 1'b0; frame_len = '0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", int'({s_ready, tx_bit, tx_en, sym_strobe, busy, done, underrun}), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 5; k++) begin
      fbytes[0] = tbl[k].b0; fbytes[1] = tbl[k].b1; fbytes[2] = tbl[k].b2;
      run_frame($sformatf("vec%0d", k), tbl[k].len, tbl[k].avail, -1, -1);
      chk($sformatf("vec%0d busy clocks", k), g_busy, tbl[k].exp_clk);
      chk($sformatf("vec%0d handshakes", k), g_hs, tbl[k].exp_hs);
      chk($sformatf("vec%0d done pulses", k), g_done, 1);
      chk($sformatf("vec%0d underrun after done", k), int'(underrun), tbl[k].exp_ur);
      if (k == 0) begin
        // Raw 1111_10100111_00 with d_new = b ^ d_prev from d=0.
        sv = 0;
        for (int i = 0; i < 14; i++) sv = (sv << 1) | g_sym[i];
        chk("empty frame symbols", sv, 14'b10101100010111);
      end
    end

    // Reset in the middle of a payload byte, then a clean one-byte frame.
    fbytes[0] = 8'h00;
    run_frame("rst_mid", 1, 1, -1, (PB + 8 + 3) * SL + 1);
    chk("rst_mid done pulses", g_done, 0);
    run_frame("post_rst", 1, 1, -1, -1);
    chk("post_rst busy clocks", g_busy, 88);
    chk("post_rst done pulses", g_done, 1);

    // Extra start during SYNC with another frame_len is ignored.
    fbytes[0] = 8'hC3; fbytes[1] = 8'h3C;
    run_frame("ign_start", 2, 2, (PB + 2) * SL + 1, -1);
    chk("ign_start busy clocks", g_busy, 120);
    chk("ign_start done pulses", g_done, 1);

    // Random frames, occasionally starving the tail end of the payload.
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(0, 6);
      avail = ($urandom_range(0, 3) == 0 && len > 0) ? $urandom_range(0, len - 1) : len;
      for (int i = 0; i < 8; i++) fbytes[i] = 8'($urandom);
      run_frame($sformatf("rnd%0d", r), len, avail, -1, -1);
      chk($sformatf("rnd%0d busy clocks", r), g_busy, (PB + 8 + 8 * len + TB) * SL);
      chk($sformatf("rnd%0d handshakes", r), g_hs, avail);
      chk($sformatf("rnd%0d done pulses", r), g_done, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
